// File: rtl/rob_commit_buffer_if.sv
// Dispatch, writeback and commit handshakes of the reorder buffer.
// The master side is the pipeline around the ROB and the slave side is the ROB itself.
interface rob_commit_buffer_if #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_W   = 5
);
  localparam int unsigned TAG_W = $clog2(DEPTH);

  logic              alloc_valid;
  logic [RD_W-1:0]   alloc_rd;
  logic              alloc_ready;
  logic [TAG_W-1:0]  alloc_tag;

  logic              wb_valid;
  logic [TAG_W-1:0]  wb_tag;
  logic [DATA_W-1:0] wb_data;

  logic              commit_valid;
  logic [RD_W-1:0]   commit_rd;
  logic [DATA_W-1:0] commit_data;
  logic              commit_ready;

  modport master (
    output alloc_valid, alloc_rd, wb_valid, wb_tag, wb_data, commit_ready,
    input  alloc_ready, alloc_tag, commit_valid, commit_rd, commit_data
  );

  modport slave (
    input  alloc_valid, alloc_rd, wb_valid, wb_tag, wb_data, commit_ready,
    output alloc_ready, alloc_tag, commit_valid, commit_rd, commit_data
  );
endinterface

// File: rtl/rob_commit_buffer.sv
// In-order reorder buffer: allocates in program order, completes out of order by tag,
// and retires the head entry to the register file once it is done.
module rob_commit_buffer #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_W   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  rob_commit_buffer_if.slave    bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                  empty,
  output logic                  full
);
  localparam int unsigned TAG_W = $clog2(DEPTH);
  localparam logic [TAG_W-1:0] PtrOne = TAG_W'(1);
  localparam logic [TAG_W:0]   CntOne = (TAG_W + 1)'(1);
  localparam logic [TAG_W:0]   CntMax = (TAG_W + 1)'(DEPTH);

  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0]             done_q, done_d;
  logic [DEPTH-1:0][RD_W-1:0]   rd_q, rd_d;
  logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
  logic [TAG_W-1:0]             head_q, head_d;
  logic [TAG_W-1:0]             tail_q, tail_d;
  logic [TAG_W:0]               count_q, count_d;

  logic alloc_fire, wb_fire, commit_fire;

  assign full  = (count_q == CntMax);
  assign empty = (count_q == '0);
  assign count = count_q;

  assign bus.alloc_ready  = ~full;
  assign bus.alloc_tag    = tail_q;
  assign bus.commit_valid = valid_q[head_q] & done_q[head_q];
  assign bus.commit_rd    = rd_q[head_q];
  assign bus.commit_data  = data_q[head_q];

  // Full is taken from the registered count, so a same-cycle commit never frees a slot early.
  assign alloc_fire  = bus.alloc_valid & ~full;
  // Only the first result for a live entry is kept; late or stray writebacks drop out here.
  assign wb_fire     = bus.wb_valid & valid_q[bus.wb_tag] & ~done_q[bus.wb_tag];
  assign commit_fire = bus.commit_valid & bus.commit_ready;

  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    rd_d    = rd_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (flush) begin
      valid_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (commit_fire) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + PtrOne;
      end
      if (alloc_fire) begin
        valid_d[tail_q] = 1'b1;
        done_d[tail_q]  = 1'b0;
        rd_d[tail_q]    = bus.alloc_rd;
        tail_d          = tail_q + PtrOne;
      end
      if (wb_fire) begin
        done_d[bus.wb_tag] = 1'b1;
        data_d[bus.wb_tag] = bus.wb_data;
      end
      unique case ({alloc_fire, commit_fire})
        2'b10:   count_d = count_q + CntOne;
        2'b01:   count_d = count_q - CntOne;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      done_q  <= '0;
      rd_q    <= '0;
      data_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_rob_commit_buffer.sv
// Directed bench for rob_commit_buffer: a vector table for the basic flow, then
// hand-written sequences for fill/wrap, ignored writebacks, flush and async reset.
module tb_rob_commit_buffer;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned RD_W   = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic [3:0] count;
  logic       empty;
  logic       full;

  int n_cmp  = 0;
  int n_fail = 0;

  rob_commit_buffer_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .RD_W(RD_W)) bus ();

  rob_commit_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .RD_W(RD_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic        wv;
    logic [2:0]  wt;
    logic [31:0] wd;
    logic        cr;
    logic        fl;
    logic [2:0]  e_at;
    logic        e_cv;
    logic [4:0]  e_crd;
    logic [31:0] e_cd;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic check_ctl(input string name, input logic [2:0] at, input logic cv,
                           input logic [3:0] cnt);
    check({name, ".alloc_tag"}, 64'(bus.alloc_tag), 64'(at));
    check({name, ".commit_valid"}, 64'(bus.commit_valid), 64'(cv));
    check({name, ".count"}, 64'(count), 64'(cnt));
    check({name, ".empty"}, 64'(empty), 64'(cnt == 4'd0));
    check({name, ".full"}, 64'(full), 64'(cnt == 4'd8));
    check({name, ".alloc_ready"}, 64'(bus.alloc_ready), 64'(cnt != 4'd8));
  endtask

  task automatic check_head(input string name, input logic [4:0] crd, input logic [31:0] cd);
    check({name, ".commit_rd"}, 64'(bus.commit_rd), 64'(crd));
    check({name, ".commit_data"}, 64'(bus.commit_data), 64'(cd));
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic wv,
                       input logic [2:0] wt, input logic [31:0] wd, input logic cr,
                       input logic fl);
    bus.alloc_valid  = av;
    bus.alloc_rd     = ard;
    bus.wb_valid     = wv;
    bus.wb_tag       = wt;
    bus.wb_data      = wd;
    bus.commit_ready = cr;
    flush            = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd1, 1'b0, 3'd0, 32'h00, 1'b0, 1'b0, 3'd1, 1'b0, 5'd1, 32'h00, 4'd1};
    vecs[1] = '{1'b1, 5'd2, 1'b0, 3'd0, 32'h00, 1'b0, 1'b0, 3'd2, 1'b0, 5'd1, 32'h00, 4'd2};
    vecs[2] = '{1'b1, 5'd3, 1'b0, 3'd0, 32'h00, 1'b0, 1'b0, 3'd3, 1'b0, 5'd1, 32'h00, 4'd3};
    vecs[3] = '{1'b0, 5'd0, 1'b1, 3'd2, 32'h33, 1'b0, 1'b0, 3'd3, 1'b0, 5'd1, 32'h00, 4'd3};
    vecs[4] = '{1'b0, 5'd0, 1'b1, 3'd0, 32'h11, 1'b0, 1'b0, 3'd3, 1'b1, 5'd1, 32'h11, 4'd3};
    vecs[5] = '{1'b0, 5'd0, 1'b1, 3'd1, 32'h22, 1'b1, 1'b0, 3'd3, 1'b1, 5'd2, 32'h22, 4'd2};
    vecs[6] = '{1'b0, 5'd0, 1'b0, 3'd0, 32'h00, 1'b1, 1'b0, 3'd3, 1'b1, 5'd3, 32'h33, 4'd1};
    vecs[7] = '{1'b0, 5'd0, 1'b0, 3'd0, 32'h00, 1'b1, 1'b0, 3'd3, 1'b0, 5'd0, 32'h00, 4'd0};

    // Reset values, both while held and after release.
    do_reset();
    check_ctl("rst_held", 3'd0, 1'b0, 4'd0);
    check_head("rst_held", 5'd0, 32'h0);
    tick();
    check_ctl("rst_rel", 3'd0, 1'b0, 4'd0);

    // Allocate three, complete out of order, retire in order.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].av, vecs[i].ard, vecs[i].wv, vecs[i].wt, vecs[i].wd, vecs[i].cr,
            vecs[i].fl);
      tick();
      check_ctl($sformatf("vec%0d", i), vecs[i].e_at, vecs[i].e_cv, vecs[i].e_cnt);
      check_head($sformatf("vec%0d", i), vecs[i].e_crd, vecs[i].e_cd);
    end
    idle();

    // Fill, refuse a ninth allocation, then wrap to tag 0 after one commit.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 5'(i + 1), 1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
      tick();
    end
    check_ctl("fill8", 3'd0, 1'b0, 4'd8);
    drive(1'b1, 5'd9, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
    tick();
    check_ctl("alloc9_refused", 3'd0, 1'b0, 4'd8);
    drive(1'b1, 5'd9, 1'b1, 3'd0, 32'hA0, 1'b0, 1'b0);
    tick();
    check_ctl("full_wb0", 3'd0, 1'b1, 4'd8);
    check_head("full_wb0", 5'd1, 32'hA0);
    drive(1'b1, 5'd9, 1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
    tick();
    check_ctl("full_commit", 3'd0, 1'b0, 4'd7);
    check_head("full_commit", 5'd2, 32'h0);
    drive(1'b1, 5'd9, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
    tick();
    check_ctl("wrap_alloc", 3'd1, 1'b0, 4'd8);
    idle();

    // First result wins; writeback to an invalid entry leaves it untouched.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'(i + 1), 1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
      tick();
    end
    check_ctl("alloc5", 3'd5, 1'b0, 4'd5);
    drive(1'b0, 5'd0, 1'b1, 3'd5, 32'h55, 1'b0, 1'b0);
    tick();
    check_ctl("wb_invalid5", 3'd5, 1'b0, 4'd5);
    drive(1'b0, 5'd0, 1'b1, 3'd0, 32'hAA, 1'b0, 1'b0);
    tick();
    check_head("wb_first", 5'd1, 32'hAA);
    drive(1'b0, 5'd0, 1'b1, 3'd0, 32'hBB, 1'b0, 1'b0);
    tick();
    check_ctl("wb_second", 3'd5, 1'b1, 4'd5);
    check_head("wb_second", 5'd1, 32'hAA);
    for (int i = 1; i < 5; i++) begin
      drive(1'b0, 5'd0, 1'b1, 3'(i), 32'(32'h10 + i), 1'b1, 1'b0);
      tick();
      check_ctl($sformatf("drain%0d", i), 3'd5, 1'b1, 4'(5 - i));
      check_head($sformatf("drain%0d", i), 5'(i + 1), 32'(32'h10 + i));
    end
    drive(1'b0, 5'd0, 1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
    tick();
    check_ctl("drained", 3'd5, 1'b0, 4'd0);
    drive(1'b0, 5'd0, 1'b1, 3'd5, 32'h55, 1'b0, 1'b0);
    tick();
    check_head("wb_invalid_head", 5'd0, 32'h0);
    check_ctl("wb_invalid_head", 3'd5, 1'b0, 4'd0);
    // Writeback to the tag being allocated this cycle is dropped.
    drive(1'b1, 5'd6, 1'b1, 3'd5, 32'h66, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    check_ctl("wb_same_alloc", 3'd6, 1'b0, 4'd1);
    check_head("wb_same_alloc", 5'd6, 32'h0);

    // Flush beats a simultaneous allocate, writeback and commit.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'(i + 1), 1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 5'd0, 1'b1, 3'(i), 32'(32'h40 + i), 1'b0, 1'b0);
      tick();
    end
    check_ctl("pre_flush", 3'd4, 1'b1, 4'd4);
    check_head("pre_flush", 5'd1, 32'h40);
    drive(1'b1, 5'd7, 1'b1, 3'd4, 32'h99, 1'b1, 1'b1);
    tick();
    check_ctl("flush", 3'd0, 1'b0, 4'd0);
    idle();
    tick();
    check_ctl("post_flush", 3'd0, 1'b0, 4'd0);

    // Asynchronous reset in the middle of traffic.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'(i + 1), 1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 5'd0, 1'b1, 3'd0, 32'h77, 1'b0, 1'b0);
    tick();
    check_ctl("pre_async", 3'd5, 1'b1, 4'd5);
    check_head("pre_async", 5'd1, 32'h77);
    drive(1'b1, 5'd3, 1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
    rst = 1'b0;
    #1;
    check_ctl("async_rst", 3'd0, 1'b0, 4'd0);
    check_head("async_rst", 5'd0, 32'h0);
    tick();
    check_ctl("rst_hold", 3'd0, 1'b0, 4'd0);
    idle();
    rst = 1'b1;
    tick();
    check_ctl("rst_release", 3'd0, 1'b0, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
